// File: rtl/memory_access_responder.sv
// memory_access_responder
// Big-endian, byte-addressable RAM responder with a fixed wait and an MFC handshake.
// A request is captured when MOV is high in IDLE. The access completes WAIT_CYCLES
// edges later, or on the capture edge itself when WAIT_CYCLES is 0. MFC then stays
// high until MOV is released.
// Optional build macro: MEMORY_TRACE_EN prints one trace line per completed access
// to the simulation transcript. Cycle behaviour is the same whether or not it is defined.

module memory_access_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        MOV,
  input  logic        Read_Write,
  input  logic [1:0]  Type,
  input  logic [31:0] Address,
  input  logic [31:0] Data_In,
  output logic [31:0] Data_Out,
  output logic        MFC,
  output logic        Misaligned
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  addr_t       addr_q, addr_d;
  logic [1:0]  type_q, type_d;
  logic        rw_q, rw_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_out_q, data_out_d;
  logic        mfc_q, mfc_d;
  logic        mis_q, mis_d;

  logic [7:0]  mem [DEPTH];

  addr_t       acc_addr, a1, a2, a3;
  logic [1:0]  acc_type;
  logic        acc_rw;
  logic [31:0] acc_wdata;
  logic        mis_c, access_c, we_c;
  logic [31:0] rdata_c;

  // The address bits above ADDR_WIDTH are intentionally ignored; addresses wrap.
  wire unused_addr_hi = &{1'b0, Address[31:ADDR_WIDTH]};

  // Pick the operands of the access. A zero-wait access completes on the capture
  // edge and takes its operands straight from the inputs. Otherwise the access uses
  // the values latched at capture.
  always_comb begin
    // NOTE: every signal written here gets a default first. Otherwise the tool infers a latch.
    acc_addr  = addr_q;
    acc_type  = type_q;
    acc_rw    = rw_q;
    acc_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      acc_addr  = Address[ADDR_WIDTH-1:0];
      acc_type  = Type;
      acc_rw    = Read_Write;
      acc_wdata = Data_In;
    end
    a1 = acc_addr + addr_t'(1);
    a2 = acc_addr + addr_t'(2);
    a3 = acc_addr + addr_t'(3);

    case (acc_type)
      2'b01:   mis_c = acc_addr[0];
      2'b10:   mis_c = |acc_addr[1:0];
      2'b11:   mis_c = 1'b1;
      default: mis_c = 1'b0;
    endcase

    rdata_c = 32'h0;
    if (acc_rw && !mis_c) begin
      case (acc_type)
        2'b00:   rdata_c = {24'h0, mem[acc_addr]};
        2'b01:   rdata_c = {16'h0, mem[acc_addr], mem[a1]};
        default: rdata_c = {mem[acc_addr], mem[a1], mem[a2], mem[a3]};
      endcase
    end

    access_c = ((state_q == S_WAIT) && (cnt_q == 4'd1)) ||
               ((state_q == S_IDLE) && MOV && (WAIT_CYCLES == 0));
    we_c     = access_c && !acc_rw && !mis_c && Reset_n;
  end

  // Next-state and next-output logic of the request FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    type_d     = type_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    mfc_d      = mfc_q;
    mis_d      = mis_q;
    case (state_q)
      S_IDLE: begin
        if (MOV) begin
          addr_d  = Address[ADDR_WIDTH-1:0];
          type_d  = Type;
          rw_d    = Read_Write;
          wdata_d = Data_In;
          cnt_d   = 4'(WAIT_CYCLES);
          mis_d   = 1'b0;
          state_d = S_WAIT;
          if (access_c) begin
            state_d    = S_DONE;
            mfc_d      = 1'b1;
            data_out_d = rdata_c;
            mis_d      = mis_c;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (access_c) begin
          state_d    = S_DONE;
          mfc_d      = 1'b1;
          data_out_d = rdata_c;
          mis_d      = mis_c;
        end
      end
      S_DONE: begin
        if (!MOV) begin
          mfc_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request FSM state, latched operands and registered outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      type_q     <= 2'b00;
      rw_q       <= 1'b0;
      wdata_q    <= 32'h0;
      data_out_q <= 32'h0;
      mfc_q      <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop sees pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      type_q     <= type_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      mfc_q      <= mfc_d;
      mis_q      <= mis_d;
    end
  end

  // Byte array write port. A write commits on the edge that enters DONE.
  // NOTE: the array has no reset. Contents survive Reset_n, and an aborted request never writes.
  always_ff @(posedge Clock) begin
    if (we_c) begin
      case (acc_type)
        2'b00: mem[acc_addr] <= acc_wdata[7:0];
        2'b01: begin
          mem[acc_addr] <= acc_wdata[15:8];
          mem[a1]       <= acc_wdata[7:0];
        end
        default: begin
          mem[acc_addr] <= acc_wdata[31:24];
          mem[a1]       <= acc_wdata[23:16];
          mem[a2]       <= acc_wdata[15:8];
          mem[a3]       <= acc_wdata[7:0];
        end
      endcase
    end
  end

`ifdef MEMORY_TRACE_EN
  // One line per completed access. The timestamp is printed in the module's time unit.
  always @(posedge Clock) begin
    if (access_c && Reset_n)
      $display("%0.2f ns %s type=%b addr=0x%h data=0x%h misaligned=%b",
               $realtime, acc_rw ? "R" : "W", acc_type, acc_addr,
               acc_rw ? rdata_c : acc_wdata, mis_c);
  end
`endif

  assign Data_Out   = data_out_q;
  assign MFC        = mfc_q;
  assign Misaligned = mis_q;

endmodule

// File: tb/tb_memory_access_responder.sv
// Scoreboard bench for memory_access_responder. It uses two instances: dut0 with the
// default wait of 2 and dut1 with a zero wait. Each request pushes its expected
// response onto that instance's queue. A monitor per instance pops an entry and
// compares it on every MFC rising edge.

module tb_memory_access_responder;

  localparam int W0 = 2;
  localparam int W1 = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mov0 = 1'b0, mov1 = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  typ = 2'b00;
  logic [31:0] addr = 32'h0, din = 32'h0;
  logic [31:0] dout0, dout1;
  logic        mfc0, mfc1, mis0, mis1;

  always #5 clk = ~clk;

  memory_access_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(W0)) dut0 (
    .Clock(clk), .Reset_n(rst_n), .MOV(mov0), .Read_Write(rw), .Type(typ),
    .Address(addr), .Data_In(din), .Data_Out(dout0), .MFC(mfc0), .Misaligned(mis0));

  memory_access_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(W1)) dut1 (
    .Clock(clk), .Reset_n(rst_n), .MOV(mov1), .Read_Write(rw), .Type(typ),
    .Address(addr), .Data_In(din), .Data_Out(dout1), .MFC(mfc1), .Misaligned(mis1));

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        chk_data;
    int          cap_edge;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, required 0x%h", nm, act, exp);
  endtask

  task automatic note_fail(input string nm);
    n_checks++;
    $display("FAIL %s: got no MFC within the cycle budget, required MFC", nm);
  endtask

  // Monitor for dut0: compare on each MFC rising edge.
  logic mfc0_prev = 1'b0;
  always @(negedge clk) begin : mon0
    exp_t e;
    if (mfc0 && !mfc0_prev) begin
      if (q0.size() == 0) begin
        n_checks++;
        $display("FAIL dut0 unexpected MFC: got MFC=1, required no response");
      end else begin
        e = q0.pop_front();
        check({e.name, " misaligned"}, 32'(mis0), 32'(e.mis));
        if (e.chk_data) check({e.name, " data"}, dout0, e.data);
        check({e.name, " latency"}, 32'(edge_cnt - e.cap_edge), 32'(W0));
      end
    end
    mfc0_prev <= mfc0;
  end

  // Monitor for dut1 (zero-wait instance).
  logic mfc1_prev = 1'b0;
  always @(negedge clk) begin : mon1
    exp_t e;
    if (mfc1 && !mfc1_prev) begin
      if (q1.size() == 0) begin
        n_checks++;
        $display("FAIL dut1 unexpected MFC: got MFC=1, required no response");
      end else begin
        e = q1.pop_front();
        check({e.name, " misaligned"}, 32'(mis1), 32'(e.mis));
        if (e.chk_data) check({e.name, " data"}, dout1, e.data);
        check({e.name, " latency"}, 32'(edge_cnt - e.cap_edge), 32'(W1));
      end
    end
    mfc1_prev <= mfc1;
  end

  // Issue one request to dut0 (sel=0) or dut1 (sel=1) and push its expectation.
  // For dut0, the request inputs are scrambled after capture to show they are latched.
  // With rst_in_done set, Reset_n is pulsed while the request sits in DONE.
  task automatic req(input int sel, input logic r, input logic [1:0] t,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic chk, input logic [31:0] ed, input logic em,
                     input string nm, input bit rst_in_done);
    exp_t e;
    int   n;
    logic seen;
    @(negedge clk);
    rw = r; typ = t; addr = a; din = d;
    if (sel == 0) mov0 = 1'b1; else mov1 = 1'b1;
    e.data = ed; e.mis = em; e.chk_data = chk; e.cap_edge = edge_cnt + 1; e.name = nm;
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
    n = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1 && sel == 0) begin
        check({nm, " misaligned cleared on capture"}, 32'(mis0), 32'h0);
        rw = ~r; typ = ~t; addr = ~a; din = ~d;
      end
      seen = (sel == 0) ? mfc0 : mfc1;
    end
    if (!seen) begin
      note_fail(nm);
      if (sel == 0) q0.delete(); else q1.delete();
    end
    if (rst_in_done) begin
      rst_n = 1'b0;
      #1 check({nm, " MFC drops on reset in DONE"}, 32'(mfc0), 32'h0);
    end
    mov0 = 1'b0;
    mov1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check({nm, " MFC released"}, 32'((sel == 0) ? mfc0 : mfc1), 32'h0);
  endtask

  logic [31:0] byte_exp [4] = '{32'h12, 32'h34, 32'h56, 32'h78};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Reset state.
    repeat (2) @(negedge clk);
    check("reset MFC", 32'(mfc0), 32'h0);
    check("reset Data_Out", dout0, 32'h0);
    check("reset Misaligned", 32'(mis0), 32'h0);
    rst_n = 1'b1;

    // First read; the array content is unknown here, so only timing is checked.
    req(0, 1'b1, 2'b10, 32'h000, 32'h0, 1'b0, 32'h0, 1'b0, "rd0 first", 1'b0);
    req(0, 1'b0, 2'b10, 32'h000, 32'h11223344, 1'b0, 32'h0, 1'b0, "wr0", 1'b0);

    // Big-endian layout.
    req(0, 1'b0, 2'b10, 32'h004, 32'h12345678, 1'b0, 32'h0, 1'b0, "wr4", 1'b0);
    for (int i = 0; i < 4; i++)
      req(0, 1'b1, 2'b00, 32'h004 + 32'(i), 32'h0, 1'b1, byte_exp[i], 1'b0,
          $sformatf("byte rd %0d", 4 + i), 1'b0);
    req(0, 1'b1, 2'b01, 32'h006, 32'h0, 1'b1, 32'h00005678, 1'b0, "half rd6", 1'b0);
    req(0, 1'b0, 2'b00, 32'h005, 32'hFFFFFFAB, 1'b0, 32'h0, 1'b0, "byte wr5", 1'b0);
    req(0, 1'b1, 2'b10, 32'h004, 32'h0, 1'b1, 32'h12AB5678, 1'b0, "word rd4", 1'b0);

    // Misaligned and reserved requests.
    req(0, 1'b0, 2'b10, 32'h002, 32'hDEADBEEF, 1'b1, 32'h0, 1'b1, "mis word wr2", 1'b0);
    req(0, 1'b1, 2'b10, 32'h000, 32'h0, 1'b1, 32'h11223344, 1'b0, "rd0 unchanged", 1'b0);
    req(0, 1'b1, 2'b01, 32'h001, 32'h0, 1'b1, 32'h0, 1'b1, "mis half rd1", 1'b0);
    req(0, 1'b1, 2'b11, 32'h000, 32'h0, 1'b1, 32'h0, 1'b1, "reserved type", 1'b0);

    // Address wrap.
    req(0, 1'b0, 2'b10, 32'h200, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, "wr 0x200", 1'b0);
    req(0, 1'b1, 2'b10, 32'h000, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, "wrap rd0", 1'b0);

    // Abort a write in WAIT with a reset pulse.
    req(0, 1'b0, 2'b10, 32'h010, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, "wr10", 1'b0);
    req(0, 1'b1, 2'b10, 32'hFFFFFE00, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, "high-bit rd", 1'b0);
    @(negedge clk);
    rw = 1'b0; typ = 2'b10; addr = 32'h010; din = 32'h0BADF00D; mov0 = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort MFC", 32'(mfc0), 32'h0);
    check("abort Data_Out", dout0, 32'h0);
    check("abort Misaligned", 32'(mis0), 32'h0);
    mov0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort no MFC", 32'(mfc0), 32'h0);
    req(0, 1'b1, 2'b10, 32'h010, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0, "rd10 after abort", 1'b0);

    // Reset in DONE keeps the completed write.
    req(0, 1'b0, 2'b10, 32'h020, 32'h77777777, 1'b0, 32'h0, 1'b0, "wr20 rst done", 1'b1);
    req(0, 1'b1, 2'b10, 32'h020, 32'h0, 1'b1, 32'h77777777, 1'b0, "rd20", 1'b0);

    // Zero-wait instance.
    req(1, 1'b0, 2'b10, 32'h040, 32'h0A0B0C0D, 1'b0, 32'h0, 1'b0, "w0 wr40", 1'b0);
    req(1, 1'b1, 2'b10, 32'h040, 32'h0, 1'b1, 32'h0A0B0C0D, 1'b0, "w0 rd40", 1'b0);
    req(1, 1'b1, 2'b01, 32'h042, 32'h0, 1'b1, 32'h00000C0D, 1'b0, "w0 half rd42", 1'b0);
    req(1, 1'b0, 2'b01, 32'h043, 32'h0, 1'b1, 32'h0, 1'b1, "w0 mis half wr", 1'b0);

    repeat (3) @(negedge clk);
    check("q0 drained", 32'(q0.size()), 32'h0);
    check("q1 drained", 32'(q1.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
